// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Round-robin arbiter for two masters in front of spi_ram. It accepts a
//   whole read or write transaction from the granted master and turns it
//   into two 10-bit command words (address word, then data/read word). For
//   reads it waits for the RAM to return a byte and hands that byte back.
//
// Optional feature (compile-time macro RAM_ARB_RD_TIMEOUT_EN):
//   When defined, a read that sees no ram_tx_valid for RD_TIMEOUT cycles is
//   aborted. The master gets rdata = all-ones and err = 1. When undefined,
//   a read waits indefinitely and err is always 0.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mN_req/we/addr/wdata         master N transaction request (level)
//   mN_ack/rdata/err             master N completion pulse, read data, timeout flag
//   ram_din, ram_rx_valid        command word to the RAM and its valid
//   ram_tx_valid, ram_dout       read byte from the RAM and its valid
//   busy                         high whenever a transaction is in progress
module spi_ram_arbiter #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [ADDR_SIZE-1:0] m0_wdata,
  output logic                 m0_ack,
  output logic [ADDR_SIZE-1:0] m0_rdata,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [ADDR_SIZE-1:0] m1_wdata,
  output logic                 m1_ack,
  output logic [ADDR_SIZE-1:0] m1_rdata,
  output logic                 m1_err,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic                 ram_tx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_ADDR = 3'd1,
    SEND_CMD  = 3'd2,
    WAIT_RD   = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t                 state_r, state_s;
  logic                   gnt_r, gnt_s;      // 0 = m0, 1 = m1
  logic                   last_r, last_s;    // master served most recently
  logic                   pick_s;
  logic                   we_r, we_s;
  logic [ADDR_SIZE-1:0]   addr_r, addr_s;
  logic [ADDR_SIZE-1:0]   wdata_r, wdata_s;
  logic [ADDR_SIZE+1:0]   ram_din_r, ram_din_s;
  logic                   ram_rx_valid_r, ram_rx_valid_s;
  logic                   m0_ack_r, m0_ack_s, m1_ack_r, m1_ack_s;
  logic                   m0_err_r, m0_err_s, m1_err_r, m1_err_s;
  logic [ADDR_SIZE-1:0]   m0_rdata_r, m0_rdata_s, m1_rdata_r, m1_rdata_s;
  logic                   busy_r, busy_s;
  logic                   resp_s;            // entering RESP this edge
  logic [ADDR_SIZE-1:0]   resp_data_s;
  logic                   resp_err_s;

`ifdef RAM_ARB_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r, cnt_s;
`else
  // The timeout length only matters in the timeout build.
  logic [31:0] rd_timeout_unused_s;
  assign rd_timeout_unused_s = 32'(RD_TIMEOUT);
`endif

  // Next-state logic. Every output is computed for the state being entered,
  // so the registered outputs line up with the state register.
  always_comb begin
    state_s        = state_r;
    gnt_s          = gnt_r;
    last_s         = last_r;
    pick_s         = 1'b0;
    we_s           = we_r;
    addr_s         = addr_r;
    wdata_s        = wdata_r;
    ram_din_s      = '0;
    ram_rx_valid_s = 1'b0;
    m0_ack_s       = 1'b0;
    m1_ack_s       = 1'b0;
    m0_err_s       = m0_err_r;
    m1_err_s       = m1_err_r;
    m0_rdata_s     = m0_rdata_r;
    m1_rdata_s     = m1_rdata_r;
    resp_s         = 1'b0;
    resp_data_s    = '0;
    resp_err_s     = 1'b0;
`ifdef RAM_ARB_RD_TIMEOUT_EN
    cnt_s          = cnt_r;
`endif

    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that was not served last wins.
          pick_s         = (m0_req && m1_req) ? ~last_r : m1_req;
          gnt_s          = pick_s;
          we_s           = pick_s ? m1_we    : m0_we;
          addr_s         = pick_s ? m1_addr  : m0_addr;
          wdata_s        = pick_s ? m1_wdata : m0_wdata;
          ram_din_s      = {(we_s ? 2'b00 : 2'b10), addr_s};
          ram_rx_valid_s = 1'b1;
          state_s        = SEND_ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      SEND_ADDR: begin
        ram_din_s      = we_r ? {2'b01, wdata_r} : {2'b11, {ADDR_SIZE{1'b0}}};
        ram_rx_valid_s = 1'b1;
        state_s        = SEND_CMD;
      end
      SEND_CMD: begin
        if (we_r) begin
          resp_s  = 1'b1;
          state_s = RESP;
        end else begin
          state_s = WAIT_RD;
`ifdef RAM_ARB_RD_TIMEOUT_EN
          cnt_s   = '0;
`endif
        end
      end
      WAIT_RD: begin
        if (ram_tx_valid) begin
          resp_s      = 1'b1;
          resp_data_s = ram_dout;
          state_s     = RESP;
        end
`ifdef RAM_ARB_RD_TIMEOUT_EN
        else if (cnt_r == CNT_W'(RD_TIMEOUT - 1)) begin
          resp_s      = 1'b1;
          resp_data_s = '1;
          resp_err_s  = 1'b1;
          state_s     = RESP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
`else
        else begin
          state_s = WAIT_RD;
        end
`endif
      end
      RESP: begin
        last_s  = gnt_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Route the completion to the granted master; writes leave rdata alone.
    if (resp_s) begin
      if (gnt_r) begin
        m1_ack_s   = 1'b1;
        m1_err_s   = resp_err_s;
        m1_rdata_s = we_r ? m1_rdata_r : resp_data_s;
      end else begin
        m0_ack_s   = 1'b1;
        m0_err_s   = resp_err_s;
        m0_rdata_s = we_r ? m0_rdata_r : resp_data_s;
      end
    end else begin
      m0_ack_s = 1'b0;
      m1_ack_s = 1'b0;
    end

    busy_s = (state_s != IDLE);
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      gnt_r          <= 1'b0;
      last_r         <= 1'b1;
      we_r           <= 1'b0;
      addr_r         <= '0;
      wdata_r        <= '0;
      ram_din_r      <= '0;
      ram_rx_valid_r <= 1'b0;
      m0_ack_r       <= 1'b0;
      m1_ack_r       <= 1'b0;
      m0_err_r       <= 1'b0;
      m1_err_r       <= 1'b0;
      m0_rdata_r     <= '0;
      m1_rdata_r     <= '0;
      busy_r         <= 1'b0;
`ifdef RAM_ARB_RD_TIMEOUT_EN
      cnt_r          <= '0;
`endif
    end else begin
      state_r        <= state_s;
      gnt_r          <= gnt_s;
      last_r         <= last_s;
      we_r           <= we_s;
      addr_r         <= addr_s;
      wdata_r        <= wdata_s;
      ram_din_r      <= ram_din_s;
      ram_rx_valid_r <= ram_rx_valid_s;
      m0_ack_r       <= m0_ack_s;
      m1_ack_r       <= m1_ack_s;
      m0_err_r       <= m0_err_s;
      m1_err_r       <= m1_err_s;
      m0_rdata_r     <= m0_rdata_s;
      m1_rdata_r     <= m1_rdata_s;
      busy_r         <= busy_s;
`ifdef RAM_ARB_RD_TIMEOUT_EN
      cnt_r          <= cnt_s;
`endif
    end
  end

  assign ram_din      = ram_din_r;
  assign ram_rx_valid = ram_rx_valid_r;
  assign m0_ack       = m0_ack_r;
  assign m1_ack       = m1_ack_r;
  assign m0_err       = m0_err_r;
  assign m1_err       = m1_err_r;
  assign m0_rdata     = m0_rdata_r;
  assign m1_rdata     = m1_rdata_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter. The bench plays both masters and
// the RAM. A byte array stands in for the RAM contents; expected command
// words, grant order, ack timing and read data come from the transaction
// rules (word formats, round-robin on ties, fixed cycle counts).
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ack, m1_ack, m0_err, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid, ram_tx_valid, busy;
  logic [7:0] ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] mem [0:255];
  logic [7:0] hold_rd [0:1];
  bit         pend [0:1];
  bit         p_we [0:1];
  logic [7:0] p_addr [0:1];
  logic [7:0] p_wdata [0:1];
  int         last_m;
  logic [3:0] order;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 1) ? m1_ack : m0_ack;
  endfunction

  function automatic logic err_of(input int m);
    return (m == 1) ? m1_err : m0_err;
  endfunction

  function automatic logic [7:0] rd_of(input int m);
    return (m == 1) ? m1_rdata : m0_rdata;
  endfunction

  task automatic apply_reqs();
    m0_req = pend[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
    m1_req = pend[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
  endtask

  task automatic raise(input int m, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
    pend[m] = 1'b1; p_we[m] = we; p_addr[m] = addr; p_wdata[m] = wdata;
    apply_reqs();
  endtask

  task automatic raise_rand(input int m);
    raise(m, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
  endtask

  // Grant rule: single requester wins; on a tie the one not served last wins.
  function automatic int pick();
    if (pend[0] && pend[1]) return 1 - last_m;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    apply_reqs();
    ram_tx_valid = 1'b0; ram_dout = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_din", 32'(ram_din), 32'h0);
    check_eq("rst_rxv", 32'(ram_rx_valid), 32'h0);
    check_eq("rst_ack", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    check_eq("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    hold_rd[0] = 8'h00; hold_rd[1] = 8'h00;
    last_m = 1;
  endtask

  // Called at the falling edge of an IDLE cycle with master m's req high and
  // m the expected winner; returns at the falling edge of the next IDLE cycle.
  task automatic run_txn(input int m, input bit no_resp);
    logic [9:0] w1, w2;
    logic [7:0] exp_rd;
    logic       exp_err, seen;
    int         o, d;
    o  = 1 - m;
    w1 = {(p_we[m] ? 2'b00 : 2'b10), p_addr[m]};
    w2 = p_we[m] ? {2'b01, p_wdata[m]} : {2'b11, 8'h00};
    exp_rd  = hold_rd[m];
    exp_err = 1'b0;
    @(negedge clk);
    check_eq("addr_rxv", 32'(ram_rx_valid), 32'h1);
    check_eq("addr_word", 32'(ram_din), 32'(w1));
    check_eq("addr_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check_eq("cmd_rxv", 32'(ram_rx_valid), 32'h1);
    check_eq("cmd_word", 32'(ram_din), 32'(w2));
    if (p_we[m]) begin
      // A stray RAM valid during a write must be ignored.
      if ($urandom_range(0, 1) == 1) begin
        ram_tx_valid = 1'b1; ram_dout = 8'($urandom);
      end
      @(negedge clk);
      ram_tx_valid = 1'b0;
      mem[p_addr[m]] = p_wdata[m];
    end else begin
      @(negedge clk);
      check_eq("wait_rxv", 32'(ram_rx_valid), 32'h0);
      check_eq("wait_din", 32'(ram_din), 32'h0);
      check_eq("wait_ack", 32'(ack_of(m)), 32'h0);
      if (no_resp) begin
        seen = 1'b0;
        repeat (15) begin
          @(negedge clk);
          seen = seen | ack_of(m);
        end
        check_eq("tmo_early_ack", 32'(seen), 32'h0);
        @(negedge clk);
        exp_rd  = 8'hFF;
        exp_err = 1'b1;
      end else begin
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        ram_tx_valid = 1'b1;
        ram_dout     = mem[p_addr[m]];
        exp_rd       = mem[p_addr[m]];
        @(negedge clk);
        ram_tx_valid = 1'b0;
        ram_dout     = 8'($urandom);
      end
      hold_rd[m] = exp_rd;
    end
    check_eq($sformatf("ack_m%0d", m), 32'(ack_of(m)), 32'h1);
    check_eq($sformatf("ack_other_m%0d", o), 32'(ack_of(o)), 32'h0);
    check_eq($sformatf("rdata_m%0d", m), 32'(rd_of(m)), 32'(exp_rd));
    check_eq($sformatf("err_m%0d", m), 32'(err_of(m)), 32'(exp_err));
    check_eq($sformatf("rdata_hold_m%0d", o), 32'(rd_of(o)), 32'(hold_rd[o]));
    pend[m] = 1'b0;
    apply_reqs();
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'h0);
    check_eq("idle_ack", 32'({m0_ack, m1_ack}), 32'h0);
    last_m = m;
  endtask

  task automatic drain();
    repeat (2) begin
      if (pend[0] || pend[1]) run_txn(pick(), 1'b0);
    end
  endtask

  initial begin
    int w;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      p_we[i] = 1'b0; p_addr[i] = 8'h00; p_wdata[i] = 8'h00;
    end
    do_reset();

    // Write then read-back through the other master.
    raise(0, 1'b1, 8'h3C, 8'hA5);
    run_txn(0, 1'b0);
    raise(1, 1'b0, 8'h3C, 8'h00);
    run_txn(1, 1'b0);
    check_eq("m1_reads_a5", 32'(m1_rdata), 32'hA5);

    // Both masters held from reset: service must alternate m0, m1, m0, m1.
    do_reset();
    raise_rand(0);
    raise_rand(1);
    order = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w = pick();
      order = {order[2:0], 1'(w)};
      run_txn(w, 1'b0);
      raise_rand(w);
    end
    check_eq("rr_order", 32'(order), 32'h5);
    drain();

    // Reset in the middle of a write's command cycle.
    raise(0, 1'b1, 8'h55, 8'h66);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rxv", 32'(ram_rx_valid), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_din", 32'(ram_din), 32'h0);
    @(negedge clk);
    check_eq("mid_rst_ack", 32'({m0_ack, m1_ack}), 32'h0);
    rst_n = 1'b1;
    hold_rd[0] = 8'h00; hold_rd[1] = 8'h00;
    last_m = 1;
    run_txn(0, 1'b0);

    // RAM valid while idle changes nothing.
    ram_tx_valid = 1'b1;
    ram_dout     = 8'h5A;
    repeat (2) @(negedge clk);
    ram_tx_valid = 1'b0;
    check_eq("idle_txv_ack", 32'({m0_ack, m1_ack}), 32'h0);
    check_eq("idle_txv_rdata", 32'({m0_rdata, m1_rdata}), 32'({hold_rd[0], hold_rd[1]}));
    check_eq("idle_txv_busy", 32'(busy), 32'h0);

`ifdef RAM_ARB_RD_TIMEOUT_EN
    // Read with no RAM response times out, then service resumes normally.
    raise(1, 1'b0, 8'h3C, 8'h00);
    run_txn(1, 1'b1);
    raise(0, 1'b0, 8'h3C, 8'h00);
    run_txn(0, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      if (!pend[0] && !pend[1] && $urandom_range(0, 2) == 0) begin
        ram_tx_valid = 1'($urandom_range(0, 1));
        ram_dout     = 8'($urandom);
        @(negedge clk);
        ram_tx_valid = 1'b0;
        check_eq("gap_ack", 32'({m0_ack, m1_ack}), 32'h0);
        check_eq("gap_rdata", 32'({m0_rdata, m1_rdata}), 32'({hold_rd[0], hold_rd[1]}));
      end
      for (int mm = 0; mm < 2; mm++) begin
        if (!pend[mm] && $urandom_range(0, 1) == 1) raise_rand(mm);
      end
      if (!pend[0] && !pend[1]) raise_rand(int'($urandom_range(0, 1)));
      run_txn(pick(), 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
